// File: rtl/io_uart_if.sv
// Core-side I/O bus of the serial port: write/read strobes, RX head byte, interrupt and status.
// int is a reserved word, so the interrupt line is carried as intr.
interface io_uart_if;
  logic [7:0] ioout;
  logic       iowrite;
  logic       ioread;
  logic [7:0] ioin;
  logic       intr;
  logic       tx_full;
  logic       tx_overrun;
  logic       rx_overrun;
  logic       frame_err;

  modport master (
    output ioout, iowrite, ioread,
    input  ioin, intr, tx_full, tx_overrun, rx_overrun, frame_err
  );

  modport slave (
    input  ioout, iowrite, ioread,
    output ioin, intr, tx_full, tx_overrun, rx_overrun, frame_err
  );
endinterface

// File: rtl/io_uart.sv
// 8N1 UART behind the core I/O bus: writes queue into a TX FIFO, received bytes queue for ioread; full FIFOs drop and flag.
// TX line starts 2 cycles after the write; IO_UART_LOOPBACK_EN feeds the RX synchronizer from the TX line instead of rxd.
module io_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdat,
  input  logic         pop,
  output logic [W-1:0] rdat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign rdat    = mem[rp];

  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= wdat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
      else if (!do_push && do_pop) cnt <= cnt - (AW+1)'(1);
    end
  end
endmodule

module io_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     clock,
  input  logic     reset,
  io_uart_if.slave bus,
  output logic     txd,
  input  logic     rxd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]    tx_bit, tx_bit_d;
  logic [7:0]    tx_sh, tx_sh_d;
  logic          tx_pop, tx_line, txd_q;
  logic [7:0]    tx_head;
  logic          tx_empty, tx_full;

  state_t        rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic [7:0]    rx_sh, rx_sh_d;
  logic          rx_armed, rx_armed_d;
  logic          rx_push, rx_ferr_set;
  logic          rx_src, rx_s1, rx_s2;
  logic [7:0]    rx_head;
  logic          rx_empty, rx_full;

  logic          tx_ovr_q, rx_ovr_q, ferr_q;

  io_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.iowrite),
    .wdat  (bus.ioout),
    .pop   (tx_pop),
    .rdat  (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  io_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .wdat  (rx_sh),
    .pop   (bus.ioread),
    .rdat  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign bus.ioin       = rx_empty ? 8'h00 : rx_head;
  assign bus.intr       = !rx_empty;
  assign bus.tx_full    = tx_full;
  assign bus.tx_overrun = tx_ovr_q;
  assign bus.rx_overrun = rx_ovr_q;
  assign bus.frame_err  = ferr_q;
  assign txd            = txd_q;

`ifdef IO_UART_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign rx_src     = txd_q;
`else
  assign rx_src     = rxd;
`endif

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_sh_d    = tx_sh;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    case (tx_state)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_cnt_d   = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_cnt == LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        tx_line = tx_sh[0];
        if (tx_cnt == LAST) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_state_d = S_STOP;
          else                tx_bit_d   = tx_bit + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        tx_line = 1'b1;
        if (tx_cnt == LAST) begin
          tx_cnt_d = '0;
          // Chain straight into the next START so queued bytes leave with no idle gap.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt + CW'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'h00;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_sh    <= tx_sh_d;
      txd_q    <= tx_line;
    end
  end

  always_comb begin
    rx_state_d  = rx_state;
    rx_cnt_d    = rx_cnt;
    rx_bit_d    = rx_bit;
    rx_sh_d     = rx_sh;
    rx_armed_d  = rx_armed;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      S_IDLE: begin
        // A start edge only counts once the line has been seen high since the last frame.
        if (!rx_armed) begin
          if (rx_s2) rx_armed_d = 1'b1;
        end else if (!rx_s2) begin
          rx_armed_d = 1'b0;
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt == HALF) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          if (rx_s2) rx_state_d = S_IDLE;
          else       rx_state_d = S_DATA;
        end else begin
          rx_cnt_d = rx_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_d = S_STOP;
          else                rx_bit_d   = rx_bit + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt == LAST) begin
          rx_cnt_d    = '0;
          rx_push     = rx_s2;
          rx_ferr_set = !rx_s2;
          rx_state_d  = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt + CW'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'h00;
      rx_armed <= 1'b0;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
      rx_armed <= rx_armed_d;
      rx_s1    <= rx_src;
      rx_s2    <= rx_s1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_ovr_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (bus.iowrite && tx_full && !tx_pop)  tx_ovr_q <= 1'b1;
      if (rx_push && rx_full && !bus.ioread)  rx_ovr_q <= 1'b1;
      if (rx_ferr_set)                        ferr_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_io_uart.sv
// Bench for io_uart at CLKS_PER_BIT=4, FIFO_DEPTH=4: TX/RX scoreboards, an RX vector table and corner sequences.
module tb_io_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rxd   = 1'b1;
  logic txd;

  io_uart_if bus();

  io_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .txd   (txd),
    .rxd   (rxd)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] tx_sb [$];
  logic [7:0] rx_sb [$];
  int         tx_starts [$];

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    logic       exp_int;
    logic       exp_ferr;
  } rxvec_t;
  rxvec_t vec [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic acc);
    bus.ioout   = d;
    bus.iowrite = 1'b1;
    tick();
    bus.iowrite = 1'b0;
    if (acc) tx_sb.push_back(d);
  endtask

  task automatic rd();
    bus.ioread = 1'b1;
    tick();
    bus.ioread = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) tick();
    end
    rxd = stop;
    repeat (CPB) tick();
    rxd = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  function automatic logic exp_a5(input int k);
    logic [7:0] v;
    v = 8'hA5;
    if (k < 2)  return 1'b1;
    if (k < 6)  return 1'b0;
    if (k < 38) return v[(k - 6) / 4];
    return 1'b1;
  endfunction

  // TX line decoder: samples mid-bit, compares each frame against the TX scoreboard.
  initial begin : tx_mon
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset && txd === 1'b0) begin
        tx_starts.push_back(cyc);
        repeat (CPB / 2) @(negedge clock);
        chk("tx_start_bit", 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clock);
        chk("tx_stop_bit", 32'(txd), 32'd1);
        repeat (CPB / 2 - 1) @(negedge clock);
        if (tx_sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected_frame: got %0h expected no frame", b);
        end else begin
          chk("tx_byte", 32'(b), 32'(tx_sb.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : main
    int n0;
    int n;
    logic exp_ovr;
    vec[0] = '{dat: 8'h3C, stop: 1'b1, exp_int: 1'b1, exp_ferr: 1'b0};
    vec[1] = '{dat: 8'hA5, stop: 1'b1, exp_int: 1'b1, exp_ferr: 1'b0};
    vec[2] = '{dat: 8'h00, stop: 1'b1, exp_int: 1'b1, exp_ferr: 1'b0};
    vec[3] = '{dat: 8'hFF, stop: 1'b1, exp_int: 1'b1, exp_ferr: 1'b0};
    vec[4] = '{dat: 8'h55, stop: 1'b0, exp_int: 1'b0, exp_ferr: 1'b1};
    bus.ioout   = 8'h00;
    bus.iowrite = 1'b0;
    bus.ioread  = 1'b0;
    exp_ovr     = 1'b0;

    // rxd activity, including a full frame's worth, while reset is held
    repeat (3) tick();
    for (int i = 0; i < 60; i++) begin
      rxd = ((i % 7) < 3) ? 1'b0 : 1'b1;
      tick();
    end
    rxd = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_int", 32'(bus.intr), 32'd0);
    chk("rst_ioin", 32'(bus.ioin), 32'h00);
    chk("rst_tx_full", 32'(bus.tx_full), 32'd0);
    chk("rst_tx_overrun", 32'(bus.tx_overrun), 32'd0);
    chk("rst_rx_overrun", 32'(bus.rx_overrun), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);

`ifdef IO_UART_LOOPBACK_EN
    tick();
    wr(8'h5A, 1'b1);
    n = 0;
    while (!bus.intr && n < 100) begin
      tick();
      n++;
    end
    @(negedge clock);
    chk("lb_int", 32'(bus.intr), 32'd1);
    chk("lb_ioin", 32'(bus.ioin), 32'h5A);
    chk("lb_latency_40_to_50", 32'(n >= 40 && n <= 50), 32'd1);
    rd();
    @(negedge clock);
    chk("lb_int_after_read", 32'(bus.intr), 32'd0);
    chk("lb_ioin_after_read", 32'(bus.ioin), 32'h00);
    repeat (20) tick();
`else
    // cycle-exact TX frame: k counts negedges after the write edge
    tick();
    wr(8'hA5, 1'b1);
    for (int k = 0; k <= 42; k++) begin
      @(negedge clock);
      chk($sformatf("tx_a5_k%0d", k), 32'(txd), 32'(exp_a5(k)));
    end
    repeat (5) tick();

    // six back-to-back writes into an idle TX with a 4-deep FIFO
    chk("tx_overrun_before", 32'(bus.tx_overrun), 32'd0);
    n0 = tx_starts.size();
    for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1);
    wr(8'h06, 1'b0);
    @(negedge clock);
    chk("burst_tx_full", 32'(bus.tx_full), 32'd1);
    chk("burst_tx_overrun", 32'(bus.tx_overrun), 32'd1);
    repeat (5 * 10 * CPB + 20) tick();
    chk("burst_frames", 32'(tx_starts.size() - n0), 32'd5);
    if (tx_starts.size() - n0 == 5) begin
      for (int i = 1; i < 5; i++)
        chk($sformatf("burst_gap%0d", i), 32'(tx_starts[n0+i] - tx_starts[n0+i-1]), 32'(10 * CPB));
    end

    // RX vector table: one frame per entry, read back after each
    for (int i = 0; i < 5; i++) begin
      send_rx(vec[i].dat, vec[i].stop);
      if (vec[i].exp_int) rx_sb.push_back(vec[i].dat);
      @(negedge clock);
      chk($sformatf("rxv%0d_int", i), 32'(bus.intr), 32'(vec[i].exp_int));
      chk($sformatf("rxv%0d_frame_err", i), 32'(bus.frame_err), 32'(vec[i].exp_ferr));
      if (rx_sb.size() > 0) begin
        chk($sformatf("rxv%0d_ioin", i), 32'(bus.ioin), 32'(rx_sb.pop_front()));
        rd();
        @(negedge clock);
        chk($sformatf("rxv%0d_int_after_read", i), 32'(bus.intr), 32'd0);
        chk($sformatf("rxv%0d_ioin_after_read", i), 32'(bus.ioin), 32'h00);
      end else begin
        chk($sformatf("rxv%0d_ioin_empty", i), 32'(bus.ioin), 32'h00);
      end
    end

    // two-cycle low glitch is a false start; the next real frame still lands
    rxd = 1'b0;
    repeat (2) tick();
    rxd = 1'b1;
    repeat (20) tick();
    @(negedge clock);
    chk("glitch_int", 32'(bus.intr), 32'd0);
    chk("glitch_rx_overrun", 32'(bus.rx_overrun), 32'd0);
    chk("glitch_frame_err_sticky", 32'(bus.frame_err), 32'd1);
    send_rx(8'h96, 1'b1);
    rx_sb.push_back(8'h96);
    @(negedge clock);
    chk("post_glitch_int", 32'(bus.intr), 32'd1);
    chk("post_glitch_ioin", 32'(bus.ioin), 32'(rx_sb.pop_front()));
    rd();

    // five frames, no reads: the fifth overruns
    for (int i = 1; i <= 5; i++) begin
      send_rx(8'(i * 8'h11), 1'b1);
      if (rx_sb.size() < DEPTH) rx_sb.push_back(8'(i * 8'h11));
      else                      exp_ovr = 1'b1;
    end
    @(negedge clock);
    chk("ovr_rx_overrun", 32'(bus.rx_overrun), 32'(exp_ovr));
    n = 0;
    while (rx_sb.size() > 0) begin
      @(negedge clock);
      chk($sformatf("ovr_int%0d", n), 32'(bus.intr), 32'd1);
      chk($sformatf("ovr_ioin%0d", n), 32'(bus.ioin), 32'(rx_sb.pop_front()));
      rd();
      n++;
    end
    @(negedge clock);
    chk("ovr_drained_int", 32'(bus.intr), 32'd0);
    chk("ovr_drained_ioin", 32'(bus.ioin), 32'h00);
`endif

    repeat (10) tick();
    chk("tx_sb_drained", 32'(tx_sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
